axi_wr_responder: RTL
=====================

// Module: axi_wr_responder
// PURPOSE
//  Slave-side AXI write responder: terminates AW/W from the interconnect, drives the
//  word-addressed SRAM write port, and generates the B response back to the master.
//  One outstanding write; INCR/FIXED bursts of size 4 B; owns BID/BRESP/BVALID.
// PARAMETERS
//  ID_W    8   AXI slave-side ID width (master ID + arbiter tag)
//  ADDR_W  32  AXI address width
//  DATA_W  32  data width; only 32 is supported, STRB_W = DATA_W/8
//  MEM_AW  14  SRAM word-address width; mem_addr = AWADDR[MEM_AW+1:2]
// PORTS
//  ACLK       in   1       clock; all logic on the rising edge
//  ARESET     in   1       synchronous reset, active-high
//  AWID       in   ID_W    write ID
//  AWADDR     in   ADDR_W  start byte address
//  AWLEN      in   4       beats-1
//  AWSIZE     in   3       beat size; only 3'b010 legal
//  AWBURST    in   2       00 FIXED, 01 INCR, 10 WRAP (unsupported)
//  AWVALID    in   1 / AWREADY  out 1   AW handshake
//  WDATA      in   DATA_W  write data
//  WSTRB      in   STRB_W  byte enables
//  WLAST      in   1       last-beat marker
//  WVALID     in   1 / WREADY   out 1   W handshake
//  BID        out  ID_W    response ID (= captured AWID)
//  BRESP      out  2       00 OKAY, 10 SLVERR
//  BVALID     out  1 / BREADY  in  1    B handshake
//  mem_we     out  1       SRAM write strobe, one cycle per accepted beat
//  mem_addr   out  MEM_AW  SRAM word address
//  mem_wdata  out  DATA_W  SRAM write data (= WDATA)
//  mem_wstrb  out  STRB_W  SRAM byte enables (= WSTRB)
// BEHAVIOUR
//  Reset: state IDLE; AWREADY=0 while ARESET=1; WREADY=0, BVALID=0, BID=0, BRESP=OKAY, mem_we=0, count=0.
//  FSM IDLE -> DATA -> RESP -> IDLE; ready/valid outputs decoded from state only.
//   IDLE: AWREADY=1. On AWVALID: latch AWID, word address, AWLEN, AWBURST; set err if
//     AWSIZE!=3'b010 or AWBURST==WRAP; clear count; go to DATA.
//   DATA: WREADY=1. Each WVALID beat: mem_we=!err in the same cycle, mem_addr=current
//     address; count++; INCR: address+1 wrapping modulo 2^MEM_AW; FIXED: address held.
//     WLAST must equal (count==len); on mismatch set err, write still performed.
//     Beat with count==len ends the burst (WLAST ignored for termination) -> RESP.
//   RESP: BVALID=1; BID=latched ID; BRESP=SLVERR if err else OKAY; stable until BREADY.
//     On BREADY -> IDLE; err cleared.
//  Latency: AW accepted in cycle N -> first W accepted no earlier than N+1; last W beat
//  in cycle M -> BVALID in M+1; B handshake in cycle K -> AWREADY in K+1 (no overlap).
//  AW and W never accepted in the same cycle; W beats while IDLE/RESP stall (WREADY=0).
//  Errored bursts drain all AWLEN+1 beats with mem_we=0, then respond SLVERR.
//  ARESET mid-burst or mid-response: transaction dropped, no B issued, outputs to reset values next edge.
// STRUCTURE
//  axi_pkg: AXI_RESP_OKAY/SLVERR/DECERR, AXI_BURST_FIXED/INCR/WRAP, AXI_SIZE_4B, wr_state_t enum {IDLE,DATA,RESP}.
//  One sub-module: axi_wr_addr_gen (latches start address/len/burst, beat counter, next-address, is_last).
// TESTING
//  1 Single write: AWID=8'h15, AWADDR=0x100, AWLEN=0, WSTRB=4'hF, WLAST=1 -> mem_we 1 cycle at
//    mem_addr=0x40, BVALID next cycle, BID=8'h15, BRESP=OKAY.
//  2 INCR AWLEN=3 at 0x200, WVALID gaps between beats -> mem_addr 0x80..0x83 in order, exactly 4 mem_we,
//    one B OKAY; WSTRB=4'b0011 passed unchanged to mem_wstrb.
//  3 BREADY held low 5 cycles -> BVALID/BID/BRESP stable 5 cycles; AWVALID asserted meanwhile gets
//    AWREADY=0 until the cycle after the B handshake.
//  4 AWBURST=WRAP, AWLEN=1 -> 2 beats accepted, mem_we never asserted, BRESP=SLVERR.
//  5 AWLEN=2 with WLAST on beat 1 -> 3 beats written, BRESP=SLVERR; INCR at word 0x3FFF wraps mem_addr to 0.
//  6 ARESET one cycle during beat 2 of AWLEN=3 -> BVALID never asserted; next AW accepted cleanly, OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-responder state type.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Burst bookkeeping: latches start word address, length and burst type,
// counts accepted beats and produces the current SRAM word address.
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MEM_AW-1:0] start_addr,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  input  logic              advance,
  output logic [MEM_AW-1:0] addr,
  output logic              is_last
);

  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path leaves it unassigned and no latch is inferred.
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    burst_d = burst_q;
    if (load) begin
      addr_d  = start_addr;
      count_d = 4'd0;
      len_d   = len;
      burst_d = burst;
    end else if (advance) begin
      count_d = count_q + 4'd1;
      if (burst_q != AXI_BURST_FIXED) addr_d = addr_q + MEM_AW'(1);
    end
  end

  // NOTE: state updates use <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      burst_q <= AXI_BURST_INCR;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

  assign addr    = addr_q;
  assign is_last = (count_q == len_q);

endmodule

// File: rtl/axi_wr_responder.sv
// AXI write slave: accepts one AW, drains its W beats into the SRAM write port,
// then returns a single B response. Ready/valid outputs are registered from next state.
module axi_wr_responder
  import axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb
);

  wr_state_t       state_q, state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            dec_err_q, dec_err_d;
  logic            last_err_q, last_err_d;

  logic              aw_fire, w_fire, b_fire, last_mismatch;
  logic [MEM_AW-1:0] beat_addr;
  logic              beat_is_last;
  logic              unused_awaddr;

  assign aw_fire       = awready_q & AWVALID;
  assign w_fire        = wready_q & WVALID;
  assign b_fire        = bvalid_q & BREADY;
  assign last_mismatch = (WLAST != beat_is_last);
  assign unused_awaddr = ^{AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

  axi_wr_addr_gen #(.MEM_AW(MEM_AW)) u_addr_gen (
    .clk        (ACLK),
    .rst        (ARESET),
    .load       (aw_fire),
    .start_addr (AWADDR[MEM_AW+1:2]),
    .len        (AWLEN),
    .burst      (AWBURST),
    .advance    (w_fire),
    .addr       (beat_addr),
    .is_last    (beat_is_last)
  );

  always_comb begin
    state_d    = state_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    dec_err_d  = dec_err_q;
    last_err_d = last_err_q;
    unique case (state_q)
      IDLE: if (aw_fire) begin
        state_d    = DATA;
        bid_d      = AWID;
        dec_err_d  = (AWSIZE != AXI_SIZE_4B) ||
                     !(AWBURST == AXI_BURST_FIXED || AWBURST == AXI_BURST_INCR);
        last_err_d = 1'b0;
      end
      // The counted length alone terminates the burst; a misplaced WLAST only poisons the response.
      DATA: if (w_fire) begin
        if (last_mismatch) last_err_d = 1'b1;
        if (beat_is_last) begin
          state_d = RESP;
          bresp_d = (dec_err_q || last_err_q || last_mismatch) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
      RESP: if (b_fire) begin
        state_d    = IDLE;
        bresp_d    = AXI_RESP_OKAY;
        dec_err_d  = 1'b0;
        last_err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= AXI_RESP_OKAY;
      dec_err_q  <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      dec_err_q  <= dec_err_d;
      last_err_q <= last_err_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

  // Bursts rejected at address time still drain their beats, just without writing.
  assign mem_we    = w_fire & ~dec_err_q;
  assign mem_addr  = beat_addr;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

endmodule
